// File: rtl/lfsr_prbs_gen.sv
// PRBS word generator: shared lfsr core driven by a two-state burst FSM with a
// valid/ready stream output. Optional error injection under PRBS_GEN_ERR_INJECT_EN.

module lfsr #(
    parameter int                    LFSR_WIDTH        = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
    parameter                        LFSR_CONFIG       = "FIBONACCI",
    parameter int                    LFSR_FEED_FORWARD = 0,
    parameter int                    REVERSE           = 0,
    parameter int                    DATA_WIDTH        = 8,
    parameter                        STYLE             = "AUTO"
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LFSR_WIDTH-1:0] state_out
);
    localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");
    localparam bit REDUCE = (STYLE == "REDUCTION");
    localparam bit FFWD   = (LFSR_FEED_FORWARD != 0);
    // Fibonacci: poly bit j taps state bit j-1; top term is implicit.
    localparam logic [LFSR_WIDTH-1:0] FIB_TAPS = LFSR_POLY >> 1;
    localparam logic [LFSR_WIDTH-1:0] GAL_TAPS = LFSR_POLY & ~{{(LFSR_WIDTH-1){1'b0}}, 1'b1};

    logic [LFSR_WIDTH-1:0] s_in, s;
    logic [DATA_WIDTH-1:0] d_in, o;
    logic                  fb, nb;

    for (genvar i = 0; i < LFSR_WIDTH; i++) begin : g_srev
        assign s_in[i]      = (REVERSE != 0) ? state_in[LFSR_WIDTH-1-i] : state_in[i];
        assign state_out[i] = (REVERSE != 0) ? s[LFSR_WIDTH-1-i] : s[i];
    end
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_drev
        assign d_in[i]     = (REVERSE != 0) ? data_in[DATA_WIDTH-1-i] : data_in[i];
        assign data_out[i] = (REVERSE != 0) ? o[DATA_WIDTH-1-i] : o[i];
    end

    // One serial step per data bit, first bit lands in the output MSB.
    always_comb begin
        s  = s_in;
        o  = '0;
        fb = 1'b0;
        nb = 1'b0;
        for (int i = DATA_WIDTH-1; i >= 0; i--) begin
            fb = s[LFSR_WIDTH-1] ^ d_in[i];
            if (!GALOIS) begin
                if (REDUCE) begin
                    fb = fb ^ (^(s & FIB_TAPS));
                end else begin
                    for (int j = 0; j < LFSR_WIDTH-1; j++)
                        if (FIB_TAPS[j]) fb = fb ^ s[j];
                end
            end
            nb = FFWD ? d_in[i] : fb;
            if (GALOIS) s = {s[LFSR_WIDTH-2:0], nb} ^ (GAL_TAPS & {LFSR_WIDTH{fb}});
            else        s = {s[LFSR_WIDTH-2:0], nb};
            o = (o << 1) | DATA_WIDTH'(fb);
        end
    end
endmodule

module lfsr_prbs_gen #(
    parameter int                    LFSR_WIDTH  = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
    parameter                        LFSR_CONFIG = "FIBONACCI",
    parameter int                    REVERSE     = 0,
    parameter int                    INVERT      = 1,
    parameter int                    DATA_WIDTH  = 8,
    parameter                        STYLE       = "AUTO"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           burst_len,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef PRBS_GEN_ERR_INJECT_EN
    input  logic                  err_inject,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           word_count
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_next;
    logic [DATA_WIDTH-1:0] lfsr_data, next_word;
    logic [15:0]           len_q;
    logic                  stop_pend;
    logic                  hs, last, load, leave, inj_flip;

    // lfsr_q sits at LFSR_INIT whenever IDLE, so one core serves both burst start and run.
    lfsr #(
        .LFSR_WIDTH(LFSR_WIDTH), .LFSR_POLY(LFSR_POLY), .LFSR_CONFIG(LFSR_CONFIG),
        .LFSR_FEED_FORWARD(0), .REVERSE(REVERSE), .DATA_WIDTH(DATA_WIDTH), .STYLE(STYLE)
    ) u_lfsr (
        .data_in  ('0),
        .state_in (lfsr_q),
        .data_out (lfsr_data),
        .state_out(lfsr_next)
    );

    assign hs    = m_valid && m_ready;
    assign last  = ((len_q != 16'd0) && ((word_count + 32'd1) == {16'd0, len_q})) || stop_pend;
    assign load  = ((state == IDLE) && start) || ((state == RUN) && hs && !last);
    assign leave = (state == RUN) && hs && last;
    assign next_word = ((INVERT != 0) ? ~lfsr_data : lfsr_data) ^ DATA_WIDTH'(inj_flip);

`ifdef PRBS_GEN_ERR_INJECT_EN
    logic inj_d, inj_arm;
    // A fresh rising edge applies to a load on the same clock; otherwise it waits armed.
    assign inj_flip = inj_arm || (err_inject && !inj_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_d   <= 1'b0;
            inj_arm <= 1'b0;
        end else begin
            inj_d <= err_inject;
            if (leave || load)              inj_arm <= 1'b0;
            else if (err_inject && !inj_d)  inj_arm <= 1'b1;
        end
    end
`else
    assign inj_flip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr_q     <= LFSR_INIT;
            m_data     <= '0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stop_pend  <= 1'b0;
            word_count <= '0;
            len_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        m_data     <= next_word;
                        m_valid    <= 1'b1;
                        lfsr_q     <= lfsr_next;
                        word_count <= '0;
                        len_q      <= burst_len;
                        busy       <= 1'b1;
                        stop_pend  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) stop_pend <= 1'b1;
                    if (hs) begin
                        if (word_count != 32'hFFFF_FFFF) word_count <= word_count + 32'd1;
                        if (last) begin
                            state     <= IDLE;
                            m_valid   <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            stop_pend <= 1'b0;
                            lfsr_q    <= LFSR_INIT;
                        end else begin
                            m_data <= next_word;
                            lfsr_q <= lfsr_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboarded bench for lfsr_prbs_gen in a PRBS7 configuration, with a
// self-synchronising descrambler as the independent stream checker.

module tb_lfsr_prbs_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] burst_len = '0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        busy, done;
    logic [31:0] word_count;
`ifdef PRBS_GEN_ERR_INJECT_EN
    logic        err_inject = 1'b0;
`endif

    lfsr_prbs_gen #(
        .LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_INIT(7'h7F), .LFSR_CONFIG("FIBONACCI"),
        .REVERSE(0), .INVERT(0), .DATA_WIDTH(8), .STYLE("AUTO")
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .burst_len(burst_len),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
`ifdef PRBS_GEN_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .busy(busy), .done(done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_err = 0;
    int         cyc = 0;
    logic [7:0] exp_w [0:511];
    logic [7:0] sb [$];
    bit         sb_en = 1'b1;
    int         hs_cnt = 0, done_cnt = 0, last_hs_cyc = 0, done_cyc = 0;
    int         chk_errs = 0, first_err_word = -1;
    logic [6:0] chk_s = 7'h7F;
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are sampled on the falling edge; they take effect on the next rising edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && m_valid && m_ready) begin
            if (sb_en) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow: got %h, expected no word", m_data);
                end else begin
                    e = sb.pop_front();
                    if (m_data !== e) begin
                        n_err++;
                        $display("FAIL word[%0d]: got %h, expected %h", hs_cnt, m_data, e);
                    end
                end
            end
            for (int i = 7; i >= 0; i--) begin
                if (m_data[i] ^ chk_s[6] ^ chk_s[5]) begin
                    chk_errs++;
                    if (first_err_word < 0) first_err_word = hs_cnt;
                end
                chk_s = {chk_s[5:0], m_data[i]};
            end
            hs_cnt++;
            last_hs_cyc = cyc;
        end
        if (rst_n && done) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = cyc;
        end
        if (rst_n && stall_prev) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== stall_data) begin
                n_err++;
                $display("FAIL stall_hold: got v=%b d=%h, expected v=1 d=%h", m_valid, m_data, stall_data);
            end
        end
        stall_prev = rst_n && m_valid && !m_ready;
        stall_data = m_data;
    end

    task automatic clear_stats();
        hs_cnt = 0; done_cnt = 0; chk_errs = 0; first_err_word = -1; chk_s = 7'h7F;
        sb.delete();
    endtask

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) sb.push_back(exp_w[k]);
    endtask

    task automatic do_start(input logic [15:0] len, input logic with_stop);
        @(posedge clk); #1;
        burst_len = len; start = 1'b1; stop = with_stop;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin timed_out = 1'b0; break; end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({m_valid, busy, done} !== 3'b000 || m_data !== 8'h00 || word_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b b=%b d=%b data=%h wc=%0d, expected all zero",
                     m_valid, busy, done, m_data, word_count);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_prbs7_burst();
        bit to;
        clear_stats();
        push_words(20);
        m_ready = 1'b1;
        @(posedge clk); #1;
        burst_len = 16'd20; start = 1'b1;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL pre_start_valid: got %b, expected 0", m_valid); end
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL first_valid: got v=%b b=%b, expected 1 1", m_valid, busy);
        end
        wait_done(100, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL prbs7_timeout: got no done, expected done"); end
        n_cmp++;
        if (hs_cnt != 20 || done_cnt != 1) begin
            n_err++; $display("FAIL prbs7_counts: got hs=%0d done=%0d, expected 20 1", hs_cnt, done_cnt);
        end
        n_cmp++;
        if (chk_errs != 0) begin n_err++; $display("FAIL prbs7_checker: got %0d error bits, expected 0", chk_errs); end
        n_cmp++;
        if (done_cyc - last_hs_cyc != 1) begin
            n_err++; $display("FAIL done_timing: got %0d cycles after last handshake, expected 1", done_cyc - last_hs_cyc);
        end
        n_cmp++;
        if (word_count !== 32'd20 || busy !== 1'b0 || m_valid !== 1'b0) begin
            n_err++; $display("FAIL prbs7_end: got wc=%0d b=%b v=%b, expected 20 0 0", word_count, busy, m_valid);
        end
    endtask

    task automatic test_stalls();
        int stall_left = 0;
        bit to = 1'b1;
        clear_stats();
        push_words(100);
        m_ready = 1'b0;
        do_start(16'd100, 1'b0);
        for (int k = 0; k < 2000; k++) begin
            if (stall_left > 0) begin
                m_ready = 1'b0; stall_left--;
            end else begin
                m_ready = 1'b1; stall_left = $urandom_range(0, 5);
            end
            @(posedge clk); #1;
            if (done_cnt > 0) begin to = 1'b0; break; end
        end
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (to) begin n_err++; $display("FAIL stall_timeout: got no done, expected done"); end
        n_cmp++;
        if (hs_cnt != 100 || word_count !== 32'd100 || done_cnt != 1) begin
            n_err++; $display("FAIL stall_counts: got hs=%0d wc=%0d done=%0d, expected 100 100 1", hs_cnt, word_count, done_cnt);
        end
    endtask

    task automatic test_continuous_stop();
        bit to = 1'b1;
        clear_stats();
        push_words(301);
        m_ready = 1'b1;
        do_start(16'd0, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            if (hs_cnt >= 300) begin to = 1'b0; break; end
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        n_cmp++;
        if (to) begin n_err++; $display("FAIL cont_timeout: got hs=%0d, expected 300", hs_cnt); end
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (m_valid !== 1'b1 || busy !== 1'b1 || done_cnt != 0) begin
            n_err++; $display("FAIL stop_hold: got v=%b b=%b done=%0d, expected 1 1 0", m_valid, busy, done_cnt);
        end
        m_ready = 1'b1;
        wait_done(20, to);
        n_cmp++;
        if (to || hs_cnt != 301 || done_cnt != 1 || word_count !== 32'd301) begin
            n_err++; $display("FAIL stop_end: got hs=%0d done=%0d wc=%0d, expected 301 1 301", hs_cnt, done_cnt, word_count);
        end
        n_cmp++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            n_err++; $display("FAIL stop_idle: got b=%b v=%b, expected 0 0", busy, m_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit to = 1'b1;
        clear_stats();
        push_words(20);
        m_ready = 1'b1;
        do_start(16'd20, 1'b0);
        for (int k = 0; k < 100; k++) begin
            if (hs_cnt >= 7) begin to = 1'b0; break; end
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (to || {m_valid, busy, done} !== 3'b000 || m_data !== 8'h00 || word_count !== 32'd0) begin
            n_err++; $display("FAIL async_reset: got v=%b b=%b d=%b data=%h wc=%0d, expected all zero",
                              m_valid, busy, done, m_data, word_count);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt != 0 || hs_cnt != 7) begin
            n_err++; $display("FAIL reset_no_done: got done=%0d hs=%0d, expected 0 7", done_cnt, hs_cnt);
        end
        clear_stats();
        push_words(3);
        do_start(16'd3, 1'b0);
        wait_done(20, to);
        n_cmp++;
        if (to || hs_cnt != 3 || done_cnt != 1) begin
            n_err++; $display("FAIL restart: got hs=%0d done=%0d, expected 3 1", hs_cnt, done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        bit to = 1'b1;
        clear_stats();
        push_words(10);
        m_ready = 1'b1;
        do_start(16'd10, 1'b0);
        for (int k = 0; k < 100; k++) begin
            if (hs_cnt >= 3) break;
            @(posedge clk); #1;
        end
        burst_len = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50, to);
        n_cmp++;
        if (to || hs_cnt != 10 || done_cnt != 1 || word_count !== 32'd10) begin
            n_err++; $display("FAIL start_in_run: got hs=%0d done=%0d wc=%0d, expected 10 1 10", hs_cnt, done_cnt, word_count);
        end
        clear_stats();
        push_words(6);
        do_start(16'd6, 1'b1);
        wait_done(50, to);
        n_cmp++;
        if (to || hs_cnt != 6 || done_cnt != 1 || word_count !== 32'd6) begin
            n_err++; $display("FAIL start_stop_idle: got hs=%0d done=%0d wc=%0d, expected 6 1 6", hs_cnt, done_cnt, word_count);
        end
    endtask

`ifdef PRBS_GEN_ERR_INJECT_EN
    task automatic test_err_inject();
        bit to = 1'b1;
        clear_stats();
        sb_en = 1'b0;
        m_ready = 1'b1;
        do_start(16'd12, 1'b0);
        for (int k = 0; k < 100; k++) begin
            if (hs_cnt >= 5) begin to = 1'b0; break; end
            @(posedge clk); #1;
        end
        err_inject = 1'b1;
        @(posedge clk); #1;
        err_inject = 1'b0;
        wait_done(50, to);
        sb_en = 1'b1;
        n_cmp++;
        if (to || chk_errs != 3 || first_err_word != 6 || hs_cnt != 12) begin
            n_err++; $display("FAIL err_inject: got errs=%0d first=%0d hs=%0d, expected 3 6 12", chk_errs, first_err_word, hs_cnt);
        end
    endtask
`endif

    initial begin
        logic [6:0] s = 7'h7F;
        logic [7:0] w;
        for (int k = 0; k < 512; k++) begin
            w = '0;
            for (int b = 0; b < 8; b++) begin
                w = {w[6:0], s[6] ^ s[5]};
                s = {s[5:0], s[6] ^ s[5]};
            end
            exp_w[k] = w;
        end
        test_reset();
        test_prbs7_burst();
        test_stalls();
        test_continuous_stop();
        test_reset_mid_burst();
        test_start_ignored();
`ifdef PRBS_GEN_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lfsr_prbs_gen.md
LFSR_PRBS_GEN -- requirements
Module: lfsr_prbs_gen

Interface
- REQ-001 The block SHALL have parameter LFSR_WIDTH, default 31: LFSR register width.
- REQ-002 The block SHALL have parameter LFSR_POLY, default 31'h10000001: feedback polynomial, implicit top term.
- REQ-003 The block SHALL have parameter LFSR_INIT, default all ones (LFSR_WIDTH bits): state after reset or at burst start.
- REQ-004 The block SHALL have parameter LFSR_CONFIG, default "FIBONACCI": "FIBONACCI" or "GALOIS".
- REQ-005 The block SHALL have parameter REVERSE, default 0: 1 = LSB-first bit order.
- REQ-006 The block SHALL have parameter INVERT, default 1: 1 = bitwise-invert the output word.
- REQ-007 The block SHALL have parameter DATA_WIDTH, default 8: output word width.
- REQ-008 The block SHALL have parameter STYLE, default "AUTO": passed to the shared lfsr core.
- REQ-009 The block SHALL have port clk, input, width 1: single clock, all logic on rising edge.
- REQ-010 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
- REQ-011 The block SHALL have port start, input, width 1: begin a burst, sampled in IDLE only.
- REQ-012 The block SHALL have port stop, input, width 1: abort the burst at the next word boundary.
- REQ-013 The block SHALL have port burst_len, input, width 16: words per burst, 0 = continuous.
- REQ-014 The block SHALL have port m_data, output, width DATA_WIDTH: PRBS word.
- REQ-015 The block SHALL have port m_valid, output, width 1: m_data valid.
- REQ-016 The block SHALL have port m_ready, input, width 1: sink accepts the word.
- REQ-017 The block SHALL have port busy, output, width 1: high in RUN.
- REQ-018 The block SHALL have port done, output, width 1: one-cycle pulse when a burst ends.
- REQ-019 The block SHALL have port word_count, output, width 32: words accepted since the last start, saturating.

Function
- REQ-020 The block SHALL instantiate the shared lfsr core with LFSR_FEED_FORWARD=0 and data_in tied to zero; lfsr_data (inverted if INVERT) SHALL be the next word and lfsr_state the next state.
- REQ-021 The FSM SHALL have exactly two states, IDLE and RUN.
- REQ-022 In IDLE with start=1, the block SHALL go to RUN, load m_data from the core output for LFSR_INIT, load the state with the next state, clear word_count and latch burst_len.
- REQ-023 The first m_valid=1 SHALL occur exactly one cycle after start is sampled.
- REQ-024 A handshake SHALL be m_valid and m_ready both high at a rising edge.
- REQ-025 On each handshake, word_count SHALL increment, saturating at 32'hFFFFFFFF.
- REQ-026 On a handshake that is not the last word, m_data SHALL load the next word and the state SHALL advance, so m_valid stays high with no bubble.
- REQ-027 A word SHALL be last when the latched burst_len is nonzero and word_count+1 equals it, or when a stop is pending.
- REQ-028 On the last handshake, m_valid SHALL drop the next cycle, the FSM SHALL return to IDLE and done SHALL pulse for one cycle.
- REQ-029 While m_valid=1 and m_ready=0, m_data and m_valid SHALL hold stable; stop SHALL NOT drop m_valid mid-word.
- REQ-030 stop SHALL be latched as pending and cleared on exit to IDLE.
- REQ-031 If stop and the last handshake coincide, the burst SHALL end once with a single done pulse.
- REQ-032 start SHALL be ignored in RUN; start and stop together in IDLE SHALL start a burst with stop ignored.
- REQ-033 With burst_len=0 the block SHALL run until stop, and the PRBS SHALL wrap naturally with no restart.
- REQ-034 Each burst SHALL restart the sequence from LFSR_INIT.

Reset
- REQ-035 On rst_n=0, regardless of clk, the block SHALL set state to IDLE, the LFSR state to LFSR_INIT, m_data to 0, m_valid, busy, done and pending stop to 0, and word_count to 0.
- REQ-036 Reset asserted mid-burst SHALL abort without a done pulse.
- REQ-037 Reset deassertion SHALL be used synchronously, with start honoured from the first edge after release.

Configuration
- REQ-038 With macro PRBS_GEN_ERR_INJECT_EN defined, the block SHALL add input port err_inject (width 1); a rising edge SHALL arm a one-shot that XORs bit 0 of the next word loaded into m_data and then disarms.
- REQ-039 An armed one-shot SHALL survive stalls and be cleared by reset or on exit to IDLE.
- REQ-040 Without PRBS_GEN_ERR_INJECT_EN, the err_inject port and its logic SHALL be absent and the output SHALL always be error-free.

Verification
- REQ-041 The bench SHALL check: PRBS7 (7, 7'h41, INVERT=0, DATA_WIDTH=8), burst_len=20, m_ready=1, looped into a matching checker -> 20 handshakes, checker output all zero, done pulses once one cycle after the 20th handshake, word_count=20.
- REQ-042 The bench SHALL check: random m_ready stalls of 0-5 cycles, burst_len=100 -> m_data stable during every stall, word stream identical to the no-stall run, word_count=100.
- REQ-043 The bench SHALL check: burst_len=0, stop pulsed after 300 handshakes while m_ready=0 -> m_valid held until accepted, exactly 301 words, one done pulse, back to IDLE.
- REQ-044 The bench SHALL check: rst_n low for 1 cycle mid-burst at word 7 -> all outputs zero asynchronously, no done pulse, next start reproduces word 0 of the sequence.
- REQ-045 The bench SHALL check, with PRBS_GEN_ERR_INJECT_EN: err_inject pulse during word 5 of PRBS7 -> checker reports exactly 3 error bits total (injected bit plus taps x6 and x7), all other words clean.
- REQ-046 The bench SHALL check: start during RUN, and start+stop in IDLE -> first ignored, second starts a burst of full burst_len.
